// File: rtl/quad_steer_decoder.sv
// Quadrature steering decoder: synchronizes the raw A/B phases, debounces them
// with a hold-count filter, and decodes accepted phase pairs into a wrapped
// absolute position, a saturating signed delta, a step pulse with direction
// and a sticky illegal-transition flag.
module quad_steer_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int POS_WIDTH     = 8
) (
   input  logic                 CLK,
   input  logic                 Reset_n,
   input  logic                 ce,
   input  logic                 steer_a,
   input  logic                 steer_b,
   input  logic                 clr,
   input  logic                 rd_delta,
   output logic [POS_WIDTH-1:0] pos,
   output logic signed [7:0]    delta,
   output logic                 step,
   output logic                 dir,
   output logic                 err,
   output logic                 primed
);

   localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILTER_CYCLES);
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic signed [7:0] DELTA_MAX = 8'sh7F;
   localparam logic signed [7:0] DELTA_MIN = 8'sh80;

   typedef enum logic [1:0] {
      MOVE_NONE,
      MOVE_RIGHT,
      MOVE_LEFT,
      MOVE_ILLEGAL
   } move_e;

   logic [2*SYNC_STAGES-1:0] syncQ;
   logic [1:0]               syncOut;

   logic [1:0]       candQ, candD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             pendValidQ, pendValidD;
   logic [1:0]       pendValQ, pendValD;

   logic [1:0]           stateQ, stateD;
   logic                 primedQ, primedD;
   logic [POS_WIDTH-1:0] posQ, posD;
   logic signed [7:0]    deltaQ, deltaD;
   logic signed [7:0]    deltaBase;
   logic                 stepQ, stepD;
   logic                 dirQ, dirD;
   logic                 errQ, errD;
   move_e                move;

   assign syncOut = syncQ[2*SYNC_STAGES-1 -: 2];

   // Shift the asynchronous phase pair through the synchronizer chain every
   // clock; the oldest pair at the top of the chain is the one the filter uses.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         syncQ <= '0;
      end else begin
         syncQ <= {syncQ[2*SYNC_STAGES-3:0], steer_a, steer_b};
      end
   end

   // Hold-count filter: a new pair restarts the count, a steady pair counts up
   // to the limit and saturates there, so each candidate is handed on exactly
   // once, on the sample where its count first reaches the limit. The handed-on
   // pair waits in a one-sample pending register for the decoder.
   always_comb begin
      candD      = candQ;
      cntD       = cntQ;
      pendValidD = pendValidQ;
      pendValD   = pendValQ;
      if (ce) begin
         pendValidD = 1'b0;
         if (syncOut != candQ) begin
            candD = syncOut;
            cntD  = CNT_ONE;
            if (FILT_MAX == CNT_ONE) begin
               pendValidD = 1'b1;
               pendValD   = syncOut;
            end
         end else if (cntQ < FILT_MAX) begin
            cntD = cntQ + CNT_ONE;
            if (cntQ == FILT_LAST) begin
               pendValidD = 1'b1;
               pendValD   = syncOut;
            end
         end
      end
   end

   // Filter candidate, hold count and pending accepted pair.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         candQ      <= '0;
         cntQ       <= '0;
         pendValidQ <= 1'b0;
         pendValQ   <= '0;
      end else begin
         candQ      <= candD;
         cntQ       <= cntD;
         pendValidQ <= pendValidD;
         pendValQ   <= pendValD;
      end
   end

   // Classify the pending pair against the last decoded pair; nothing is
   // classified until the decoder has been primed by its first accepted pair.
   always_comb begin
      move = MOVE_NONE;
      if (ce && pendValidQ && primedQ) begin
         case ({stateQ, pendValQ})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move = MOVE_RIGHT;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MOVE_LEFT;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: move = MOVE_ILLEGAL;
            default:                                move = MOVE_NONE;
         endcase
      end
   end

   // Next outputs: a read strobe restarts delta from zero before the current
   // step is added so the step is never lost, clear forces position to zero
   // but loses to an illegal transition arriving on the same cycle.
   always_comb begin
      stateD  = stateQ;
      primedD = primedQ;
      posD    = posQ;
      stepD   = 1'b0;
      dirD    = dirQ;
      errD    = errQ;
      deltaBase = rd_delta ? 8'sh00 : deltaQ;
      deltaD    = deltaBase;
      if (ce && pendValidQ) begin
         stateD  = pendValQ;
         primedD = 1'b1;
      end
      case (move)
         MOVE_RIGHT: begin
            posD  = posQ + POS_WIDTH'(1);
            deltaD = (deltaBase == DELTA_MAX) ? DELTA_MAX : deltaBase + 8'sh01;
            dirD  = 1'b1;
            stepD = 1'b1;
         end
         MOVE_LEFT: begin
            posD  = posQ - POS_WIDTH'(1);
            deltaD = (deltaBase == DELTA_MIN) ? DELTA_MIN : deltaBase - 8'sh01;
            dirD  = 1'b0;
            stepD = 1'b1;
         end
         MOVE_ILLEGAL: begin
            errD = 1'b1;
         end
         default: begin
            errD = errQ;
         end
      endcase
      if (clr) begin
         posD = '0;
         errD = (move == MOVE_ILLEGAL);
      end
   end

   // Decoder state and registered outputs.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         stateQ  <= '0;
         primedQ <= 1'b0;
         posQ    <= '0;
         deltaQ  <= '0;
         stepQ   <= 1'b0;
         dirQ    <= 1'b0;
         errQ    <= 1'b0;
      end else begin
         stateQ  <= stateD;
         primedQ <= primedD;
         posQ    <= posD;
         deltaQ  <= deltaD;
         stepQ   <= stepD;
         dirQ    <= dirD;
         errQ    <= errD;
      end
   end

   assign pos    = posQ;
   assign delta  = deltaQ;
   assign step   = stepQ;
   assign dir    = dirQ;
   assign err    = errQ;
   assign primed = primedQ;

endmodule
